sram_model: RTL and testbench

- Behavioural single-port synchronous-write, asynchronous-read SRAM for system simulation beside the arm core.
- 32-bit words addressed by a 17-bit word address over one bidirectional data bus with an active-low write enable.
- Clocked by the dedicated SRAM clock; in the system this runs at half the core clock (25 MHz vs 50 MHz).
- Presence in the system is selected by the `USE_SRAM configuration switch.

---
 rtl/arm_cfg_pkg.sv | 12 +
 rtl/sram_model_if.sv | 19 +
 rtl/sram_model.sv | 41 ++++
 tb/tb_sram_model.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arm_cfg_pkg.sv
// rtl/arm_cfg_pkg.sv - shared configuration constants and types for the arm system model
package arm_cfg_pkg;

    // System-level switch selecting whether the external SRAM model is present.
    localparam bit USE_SRAM = 1'b1;

    localparam int SRAM_ADDR_WIDTH = 17;
    localparam int SRAM_DATA_WIDTH = 32;

    typedef logic [SRAM_DATA_WIDTH-1:0] sram_word_t;

endpackage

// File: rtl/sram_model_if.sv
// rtl/sram_model_if.sv - control/address group of the external SRAM bus
interface sram_model_if #(
    parameter int ADDR_WIDTH = arm_cfg_pkg::SRAM_ADDR_WIDTH
) ();

    logic                  SRAM_WE_N;
    logic [ADDR_WIDTH-1:0] SRAM_ADDR;

    modport master (
        output SRAM_WE_N,
        output SRAM_ADDR
    );

    modport slave (
        input  SRAM_WE_N,
        input  SRAM_ADDR
    );

endinterface

// File: rtl/sram_model.sv
// rtl/sram_model.sv - behavioural SRAM: synchronous write, combinational read, shared tristate data bus
module sram_model
    import arm_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    sram_model_if.slave           bus,
    inout  wire  [DATA_WIDTH-1:0] SRAM_DQ
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents start at zero and are deliberately untouched by RST.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic                  ctl_unknown;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign ctl_unknown = $isunknown({bus.SRAM_WE_N, bus.SRAM_ADDR});

    // RST is sampled at the edge, so a write pending when reset rises is simply never taken.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!ctl_unknown)
                else $warning("sram_model: unknown SRAM_WE_N/SRAM_ADDR at write edge, array not updated");
            if (!ctl_unknown && !bus.SRAM_WE_N) begin
                mem[bus.SRAM_ADDR] <= SRAM_DQ;
            end
        end
    end

    // An unknown control on the read path poisons the bus rather than returning a plausible word.
    assign rd_data  = ctl_unknown ? {DATA_WIDTH{1'bx}} : mem[bus.SRAM_ADDR];
    assign drive_en = !RST && (bus.SRAM_WE_N || ctl_unknown);
    assign SRAM_DQ  = drive_en ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_model.sv
// tb/tb_sram_model.sv - directed and randomized checks of sram_model against an address-keyed reference
module tb_sram_model;
    import arm_cfg_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        tb_dq_en = 1'b0;
    logic [31:0] tb_dq_val = 32'h0;
    wire  [31:0] SRAM_DQ;

    sram_model_if bus_if ();

    assign SRAM_DQ = tb_dq_en ? tb_dq_val : 32'bz;

    sram_model dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus_if.slave),
        .SRAM_DQ (SRAM_DQ)
    );

    always #20 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference: only addresses ever written are stored; everything else reads as zero.
    logic [31:0] model [int];

    function automatic logic [31:0] expect_at(input int a);
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    // Write is accepted only if RST is low at the rising edge; the model applies that rule itself.
    task automatic do_write(input logic [16:0] a, input logic [31:0] d);
        @(negedge CLK);
        bus_if.SRAM_ADDR = a;
        bus_if.SRAM_WE_N = 1'b0;
        tb_dq_val        = d;
        tb_dq_en         = 1'b1;
        @(posedge CLK);
        if (!RST) model[int'(a)] = d;
        #1;
        bus_if.SRAM_WE_N = 1'b1;
        tb_dq_en         = 1'b0;
    endtask

    task automatic read_check(input logic [16:0] a, input string tag);
        bus_if.SRAM_ADDR = a;
        bus_if.SRAM_WE_N = 1'b1;
        tb_dq_en         = 1'b0;
        #1;
        check(tag, SRAM_DQ, expect_at(int'(a)));
    endtask

    // The bench drives a pattern; if the DUT is also driving, the resolved bus differs from it.
    task automatic hiz_check(input string tag, input logic [31:0] pat);
        tb_dq_val = pat;
        tb_dq_en  = 1'b1;
        #1;
        check(tag, SRAM_DQ, pat);
        tb_dq_en  = 1'b0;
        #1;
    endtask

    initial begin
        logic [16:0] a;
        logic [31:0] d;

        bus_if.SRAM_WE_N = 1'b1;
        bus_if.SRAM_ADDR = 17'h00010;
        #5;
        hiz_check("reset_state_hiz", 32'h3C3C3C3C);

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        read_check(17'h00010, "post_reset_zero");

        do_write(17'h00010, 32'hDEADBEEF);
        read_check(17'h00010, "write_read");

        @(negedge CLK);
        bus_if.SRAM_ADDR = 17'h00010;
        bus_if.SRAM_WE_N = 1'b0;
        hiz_check("we_low_hiz", 32'h0F0F0F0F);
        bus_if.SRAM_WE_N = 1'b1;
        read_check(17'h00020, "unwritten_zero");

        do_write(17'h00000, 32'h11111111);
        do_write(17'h1FFFF, 32'h22222222);
        read_check(17'h00000, "bound_low");
        read_check(17'h1FFFF, "bound_high");
        read_check(17'h00001, "no_alias_low");
        read_check(17'h0FFFF, "no_alias_mid");
        check("bound_low_const", expect_at(0), 32'h11111111);

        do_write(17'h00100, 32'hA5A5A5A5);
        do_write(17'h00100, 32'h5A5A5A5A);
        read_check(17'h00100, "last_write_wins");

        do_write(17'h00040, 32'hCAFEF00D);
        @(negedge CLK);
        read_check(17'h00040, "pre_reset_read");
        #2;
        RST = 1'b1;
        hiz_check("rst_async_hiz", 32'h12345678);
        do_write(17'h00040, 32'h00000000);
        hiz_check("rst_held_hiz", 32'h81818181);
        @(negedge CLK);
        bus_if.SRAM_ADDR = 17'h00040;
        bus_if.SRAM_WE_N = 1'b0;
        tb_dq_val        = 32'h0;
        tb_dq_en         = 1'b1;
        #4;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.SRAM_WE_N = 1'b1;
        tb_dq_en         = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        read_check(17'h00040, "retained_after_reset");
        check("model_retained", expect_at(32'h40), 32'hCAFEF00D);

        do_write(17'h00041, 32'h0BADF00D);
        read_check(17'h00041, "first_write_after_release");

        @(negedge CLK);
        read_check(17'h00010, "comb_step_a");
        read_check(17'h00040, "comb_step_b");
        read_check(17'h00010, "comb_step_c");
        read_check(17'h00041, "comb_step_d");

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 15))
                                            : 17'($urandom_range(0, 17'h1FFFF));
            d = $urandom;
            do_write(a, d);
            read_check(a, "rand_wr_rd");
            read_check(17'($urandom_range(0, 15)), "rand_pool_rd");
        end

        @(negedge CLK);
        foreach (model[k]) begin
            read_check(k[16:0], "final_sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
